cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus arbiter sharing the single result broadcast bus among the execution-side producers: the reservation-station ALU, the load/store buffer, and a spare port for a future unit. Each producer writes results into a small private FIFO; a round-robin scheduler drains one result per cycle onto a registered CDB. The CDB is consumed by the ROB, the reservation station and the LSB for wakeup and forwarding. Producers no longer broadcast directly and no longer need one forwarding port per consumer.

## Interface
- ROB_WIDTH, 4, ROB tag width
- NUM_SRC, 3, number of producers (0 = ALU, 1 = LSB, 2 = spare); legal range 2..4
- FIFO_WIDTH, 1, log2 of per-source FIFO depth (depth 2 by default)

Ports:
- clockIn  in  1  sole clock, rising edge
- resetIn  in  1  asynchronous, active-high reset
- readyIn  in  1  global enable; low = all state holds
- flushIn  in  1  mispredict flush; discards all buffered and outgoing results
- srcFlag  in  NUM_SRC  per-source result valid
- srcVal  in  NUM_SRC*32  per-source result value, source i at bits [32i+31:32i]
- srcDest  in  NUM_SRC*ROB_WIDTH  per-source ROB tag
- srcFull  out  NUM_SRC  per-source backpressure; registered, high when that FIFO holds depth entries
- cdbFlag  out  1  broadcast valid
- cdbVal  out  32  broadcast value
- cdbDest  out  ROB_WIDTH  broadcast ROB tag
- cdbSrc  out  2  index of the granted source, for debug and performance counters

## Operation
- Push: on an edge with readyIn=1, flushIn=0 and srcFlag[i]=1, {srcVal, srcDest} of source i is appended to FIFO i.
  - srcFlag[i] while srcFull[i]=1 is a protocol violation. The entry is dropped, FIFO state is unchanged, and a simulation assertion fires.
  - srcFull is computed from the pre-edge count. A same-cycle pop does not free a slot for a push in that cycle.
- Grant (combinational): scan sources starting at rrPtr, wrapping modulo NUM_SRC; the first non-empty FIFO wins.
- Pop: on an edge with readyIn=1 and flushIn=0:
  - If any FIFO is non-empty: the granted FIFO's head moves into cdbVal/cdbDest, cdbSrc takes the grant index, cdbFlag<=1, and rrPtr<=(grant+1) mod NUM_SRC.
  - If all FIFOs are empty: cdbFlag<=0; cdbVal, cdbDest and cdbSrc hold; rrPtr holds.
- Simultaneous push and pop on the same FIFO is legal. The count is unchanged and order is preserved.
- A result pushed into an empty FIFO is not grantable in the cycle it is pushed.
- Flush: on an edge with flushIn=1, regardless of readyIn:
  - All FIFOs empty, cdbFlag<=0, rrPtr<=0, srcFull<=0.
  - Pushes in the flush cycle are discarded.
- readyIn=0 with flushIn=0: FIFOs, rrPtr and all outputs hold. cdbFlag is not cleared, because consumers are gated by the same readyIn.
- Reset (asynchronous, any time, including mid-transfer): FIFOs empty, rrPtr=0, cdbFlag=0, cdbVal=0, cdbDest=0, cdbSrc=0, srcFull=0.
- Ordering: per source, FIFO order. Across sources, no ordering guarantee.

## Timing
- Latency with no contention: srcFlag sampled at edge N, cdbFlag high during the cycle after edge N+1 (2 edges).
- Throughput: one broadcast per enabled cycle. A source with k queued entries under full contention waits at most (NUM_SRC-1) grants between its own grants.
- All outputs are registered; no combinational path from src* or flushIn to any output.
- srcFull rises on the edge where the count reaches depth. It falls on the edge where a pop leaves the count below depth.

## Structure
- Shared package cdb_pkg:
  - CDB entry typedef {val[31:0], dest[ROB_WIDTH-1:0]}
  - source-index constants SRC_ALU=0, SRC_LSB=1, SRC_SPARE=2
  - round-robin helper function next_ptr(ptr, NUM_SRC)
- Sub-module cdb_fifo: parameterized by FIFO_WIDTH and entry width.
  - Contains head/tail pointers, a count one bit wider than the pointers, and full/empty flags.
  - Takes push, pop and flush inputs; instantiated NUM_SRC times.
- Top level holds the grant scan, rrPtr and the output registers.

## Test plan
- Single source: ALU pushes val=0x11, dest=3 at edge 0 -> cdbFlag=1, cdbVal=0x11, cdbDest=3, cdbSrc=0 in the cycle after edge 1; cdbFlag=0 next cycle.
- Contention: all three sources push in the same cycle with rrPtr=0 (vals 0xA0, 0xB0, 0xC0) -> CDB carries 0xA0, 0xB0, 0xC0 on three consecutive cycles, cdbSrc 0,1,2; final rrPtr=0.
- Backpressure: LSB pushes twice with no grants available (ALU streaming continuously at higher priority in rotation) -> srcFull[1]=1 after the second push. A third push is dropped and the assertion fires. Entries are later broadcast in order.
- Stall: readyIn=0 for 3 cycles while cdbFlag=1 and FIFOs are non-empty -> outputs, counts and srcFull are unchanged. Draining resumes on the first readyIn=1 edge.
- Flush: FIFOs hold 4 entries and cdbFlag=1; assert flushIn with readyIn=0 and a simultaneous ALU push -> next cycle cdbFlag=0, all srcFull=0, rrPtr=0, no further broadcasts.
- Async reset: assert resetIn between clock edges mid-drain -> all outputs are 0 immediately, before the next edge, and the FIFOs are empty after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter and its consumers.
package cdb_pkg;

  localparam int ROB_W = 4;

  localparam logic [1:0] SRC_ALU   = 2'd0;
  localparam logic [1:0] SRC_LSB   = 2'd1;
  localparam logic [1:0] SRC_SPARE = 2'd2;

  typedef struct packed {
    logic [31:0]      val;
    logic [ROB_W-1:0] dest;
  } cdbEntry_t;

  // Round-robin successor of a source index, wrapping at numSrc.
  function automatic logic [1:0] next_ptr(input logic [1:0] ptr, input int numSrc);
    if (int'(ptr) + 1 >= numSrc) return 2'd0;
    return ptr + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-producer result FIFO: circular buffer with a count one bit wider than the pointers.
module cdb_fifo #(
  parameter int FIFO_WIDTH = 1,
  parameter int ENTRY_W    = 36
) (
  input  logic               clockIn,
  input  logic               resetIn,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wrData,
  output logic [ENTRY_W-1:0] rdData,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam int CNT_W = FIFO_WIDTH + 1;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [FIFO_WIDTH-1:0] head;
  logic [FIFO_WIDTH-1:0] tail;
  logic [CNT_W-1:0]      count;
  logic                  doPush;
  logic                  doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  // A push into a full FIFO is dropped; full is judged on the pre-edge count.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[head];

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doPush) tail <= tail + 1'b1;
      if (doPop)  head <= head + 1'b1;
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // NOTE: storage is not reset; only pointers and count define validity.
  always_ff @(posedge clockIn) begin
    if (doPush && !flush) mem[tail] <= wrData;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-producer FIFOs drained round-robin onto a registered broadcast bus.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int ROB_WIDTH  = ROB_W,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_WIDTH = 1
) (
  input  logic                           clockIn,
  input  logic                           resetIn,
  input  logic                           readyIn,
  input  logic                           flushIn,
  input  logic [NUM_SRC-1:0]             srcFlag,
  input  logic [NUM_SRC*32-1:0]          srcVal,
  input  logic [NUM_SRC*ROB_WIDTH-1:0]   srcDest,
  output logic [NUM_SRC-1:0]             srcFull,
  output logic                           cdbFlag,
  output logic [31:0]                    cdbVal,
  output logic [ROB_WIDTH-1:0]           cdbDest,
  output logic [1:0]                     cdbSrc
);

  typedef struct packed {
    logic [31:0]          val;
    logic [ROB_WIDTH-1:0] dest;
  } entry_t;

  entry_t             fifoHead [NUM_SRC];
  logic [NUM_SRC-1:0] fifoEmpty;
  logic [NUM_SRC-1:0] fifoFull;
  logic [NUM_SRC-1:0] popVec;
  logic [3:0]         srcNonEmpty;
  logic [2:0]         scanSum;
  logic [1:0]         rrPtr;
  logic [1:0]         grantIdx;
  logic               anyValid;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_fifo #(
      .FIFO_WIDTH(FIFO_WIDTH),
      .ENTRY_W   ($bits(entry_t))
    ) u_fifo (
      .clockIn(clockIn),
      .resetIn(resetIn),
      .flush  (flushIn),
      .push   (readyIn && srcFlag[i]),
      .pop    (popVec[i]),
      .wrData ({srcVal[32*i +: 32], srcDest[ROB_WIDTH*i +: ROB_WIDTH]}),
      .rdData (fifoHead[i]),
      .full   (fifoFull[i]),
      .empty  (fifoEmpty[i])
    );

    always @(posedge clockIn) begin
      if (!resetIn && readyIn && !flushIn && srcFlag[i])
        assert (!fifoFull[i]) else $warning("cdb_arbiter: push on full source %0d dropped", i);
    end
  end

  assign srcFull = fifoFull;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    anyValid    = 1'b0;
    grantIdx    = rrPtr;
    scanSum     = '0;
    srcNonEmpty = '0;
    srcNonEmpty[NUM_SRC-1:0] = ~fifoEmpty;
    for (int k = 0; k < NUM_SRC; k++) begin
      scanSum = {1'b0, rrPtr} + 3'(k);
      if (scanSum >= 3'(NUM_SRC)) scanSum = scanSum - 3'(NUM_SRC);
      if (!anyValid && srcNonEmpty[scanSum[1:0]]) begin
        anyValid = 1'b1;
        grantIdx = scanSum[1:0];
      end
    end
  end

  always_comb begin
    popVec = '0;
    for (int i = 0; i < NUM_SRC; i++)
      popVec[i] = readyIn && !flushIn && anyValid && (grantIdx == 2'(i));
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      rrPtr   <= '0;
      cdbFlag <= 1'b0;
      cdbVal  <= '0;
      cdbDest <= '0;
      cdbSrc  <= '0;
    end else if (flushIn) begin
      rrPtr   <= '0;
      cdbFlag <= 1'b0;
    end else if (readyIn) begin
      if (anyValid) begin
        cdbFlag <= 1'b1;
        cdbVal  <= fifoHead[grantIdx].val;
        cdbDest <= fifoHead[grantIdx].dest;
        cdbSrc  <= grantIdx;
        rrPtr   <= next_ptr(grantIdx, NUM_SRC);
      end else begin
        cdbFlag <= 1'b0;
      end
    end
  end

endmodule
